// File: rtl/sierpinski_pkg.sv
// -----------------------------------------------------------------------------
// sierpinski_pkg
// Shared constants for the Sierpinski / LFSR pattern tile:
//   LFSR_SEED  reset and zero-seed replacement value for the LFSR
//   CA_SEED    reset and zero-row replacement value for the rule-90 row
//   LFSR_TAPS  feedback tap mask, taps at bits {7,5,4,3}
//   mode_e     output-mux selection carried on ui_in[1:0]
// -----------------------------------------------------------------------------
package sierpinski_pkg;

   localparam logic [7:0] LFSR_SEED = 8'h01;
   localparam logic [7:0] CA_SEED   = 8'h08;

   // x^8 + x^6 + x^5 + x^4 + 1, a maximal-length polynomial (period 255).
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   typedef enum logic [1:0] {
      MODE_LFSR = 2'd0,
      MODE_CA   = 2'd1,
      MODE_XOR  = 2'd2,
      MODE_CNT  = 2'd3
   } mode_e;

   // One Fibonacci step: shift left, feedback is the parity of the tapped bits.
   function automatic logic [7:0] lfsr_next(input logic [7:0] q);
      return {q[6:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage : sierpinski_pkg

// File: rtl/sierpinski_if.sv
// -----------------------------------------------------------------------------
// sierpinski_if
// Link between the tile top level and the rule-90 next-row function.
//   row  current cellular-automaton row (driven by the register owner)
//   nxt  next row, already reseeded if it would have been all zero
// Modports:
//   master  owns the row register: drives row, reads nxt
//   slave   combinational row function: reads row, drives nxt
// -----------------------------------------------------------------------------
interface sierpinski_if;

   logic [7:0] row;
   logic [7:0] nxt;

   modport master (output row, input nxt);
   modport slave  (input row, output nxt);

endinterface : sierpinski_if

// File: rtl/rule90_row.sv
// -----------------------------------------------------------------------------
// rule90_row
// Combinational next-row function of an 8-cell rule-90 automaton with null
// (always-zero) cells beyond both ends: nxt[i] = row[i-1] ^ row[i+1].
// An all-zero result is replaced by CA_SEED so the pattern never dies out.
// Ports:
//   row_if  sierpinski_if.slave  (row in, nxt out)
// -----------------------------------------------------------------------------
module rule90_row
   import sierpinski_pkg::*;
(
   sierpinski_if.slave row_if
);

   logic [7:0] raw;

   // Shifting in zeros at both ends supplies the null boundary cells.
   assign raw = {row_if.row[6:0], 1'b0} ^ {1'b0, row_if.row[7:1]};

   assign row_if.nxt = (raw == 8'h00) ? CA_SEED : raw;

endmodule : rule90_row

// File: rtl/tt_um_sierpinski_lfsr.sv
// -----------------------------------------------------------------------------
// tt_um_sierpinski_lfsr
// Tiny Tapeout tile producing an 8-bit maximal-length LFSR, a rule-90
// (Sierpinski) row and a step counter; ui_in[1:0] picks which one, or the
// LFSR ^ row mix, drives uo_out.
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous reset, ACTIVE-HIGH despite the harness name
//   ena      harness enable, ignored
//   ui_in    [1:0] mode, [2] run, [3] load, [7:4] unused
//   uio_in   seed for load
//   uo_out   selected pattern (combinational from the registers)
//   uio_out  constant 0x00
//   uio_oe   constant 0x00, all bidirectional pins stay inputs
// Priority per edge: reset > load > run > hold. No handshake: run held high
// steps every cycle.
// -----------------------------------------------------------------------------
module tt_um_sierpinski_lfsr
   import sierpinski_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [7:0] lfsr_q, lfsr_d;
   logic [7:0] ca_q,   ca_d;
   logic [7:0] cnt_q,  cnt_d;

   mode_e mode;
   logic  run;
   logic  load;

   sierpinski_if ca_link ();

   assign mode = mode_e'(ui_in[1:0]);
   assign run  = ui_in[2];
   assign load = ui_in[3];

   // Deliberately unused inputs, collected so lint sees them consumed.
   logic unused_inputs;
   assign unused_inputs = &{1'b0, ena, ui_in[7:4]};

   assign ca_link.row = ca_q;

   rule90_row u_rule90_row (
      .row_if (ca_link.slave)
   );

   always_comb begin
      lfsr_d = lfsr_q;
      ca_d   = ca_q;
      cnt_d  = cnt_q;
      if (load) begin
         // A zero seed would lock the LFSR and blank the automaton.
         lfsr_d = (uio_in == 8'h00) ? LFSR_SEED : uio_in;
         ca_d   = (uio_in == 8'h00) ? CA_SEED   : uio_in;
         cnt_d  = 8'h00;
      end else if (run) begin
         lfsr_d = lfsr_next(lfsr_q);
         ca_d   = ca_link.nxt;
         cnt_d  = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         lfsr_q <= LFSR_SEED;
         ca_q   <= CA_SEED;
         cnt_q  <= 8'h00;
      end else begin
         lfsr_q <= lfsr_d;
         ca_q   <= ca_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      uo_out = lfsr_q;
      case (mode)
         MODE_LFSR: uo_out = lfsr_q;
         MODE_CA:   uo_out = ca_q;
         MODE_XOR:  uo_out = lfsr_q ^ ca_q;
         MODE_CNT:  uo_out = cnt_q;
         default:   uo_out = lfsr_q;
      endcase
   end

   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

endmodule : tt_um_sierpinski_lfsr

// File: tb/tb_tt_um_sierpinski_lfsr.sv
// -----------------------------------------------------------------------------
// tb_tt_um_sierpinski_lfsr
// Directed bench for the Sierpinski / LFSR tile plus a few standalone vectors
// for the rule-90 row function (including its zero-row reseed, which the tile
// itself can never reach because the 8-cell rule-90 map is invertible).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_tt_um_sierpinski_lfsr;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks = 0;
   int errors = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   tt_um_sierpinski_lfsr dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   // Standalone row-function instance for direct vectors.
   sierpinski_if r_if ();
   rule90_row u_row (
      .row_if (r_if.slave)
   );

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   // Independent per-cell rule-90 reference with explicit null boundaries.
   function automatic logic [7:0] ca_ref(input logic [7:0] c);
      logic [7:0] n;
      logic l, r;
      for (int i = 0; i < 8; i++) begin
         l = (i == 0) ? 1'b0 : c[i-1];
         r = (i == 7) ? 1'b0 : c[i+1];
         n[i] = l ^ r;
      end
      if (n == 8'h00) n = 8'h08;
      return n;
   endfunction

   // ---------------- directed sequence ----------------
   initial begin
      logic [7:0] ca_m;
      int         first_ret;
      logic [7:0] lfsr_exp [5];
      logic [7:0] ca_exp   [4];

      lfsr_exp = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
      ca_exp   = '{8'h14, 8'h22, 8'h55, 8'h80};

      rst_n  = 1'b1;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      r_if.row = 8'h00;

      // Row function vectors, including the zero-row reseed.
      r_if.row = 8'h01; #1; check("row_01", r_if.nxt, 8'h02);
      r_if.row = 8'h80; #1; check("row_80", r_if.nxt, 8'h40);
      r_if.row = 8'hFF; #1; check("row_ff", r_if.nxt, 8'h81);
      r_if.row = 8'hA5; #1; check("row_a5", r_if.nxt, 8'h18);
      r_if.row = 8'h00; #1; check("row_zero_reseed", r_if.nxt, 8'h08);

      // Reset values for every mode.
      step(); step();
      ui_in = 8'h00; #1; check("rst_mode00", uo_out, 8'h01);
      ui_in = 8'h01; #1; check("rst_mode01", uo_out, 8'h08);
      ui_in = 8'h02; #1; check("rst_mode10", uo_out, 8'h09);
      ui_in = 8'h03; #1; check("rst_mode11", uo_out, 8'h00);
      check("uio_out", uio_out, 8'h00);
      check("uio_oe", uio_oe, 8'h00);

      // LFSR first steps.
      rst_n = 1'b0;
      ui_in = 8'h04;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("lfsr_step%0d", i + 1), uo_out, lfsr_exp[i]);
      end

      // LFSR full period from reset, plus the counter across the same steps.
      rst_n = 1'b1; step(); rst_n = 1'b0;
      ui_in = 8'h04;
      first_ret = 0;
      for (int i = 1; i <= 255; i++) begin
         step();
         check("lfsr_nonzero", {7'b0, uo_out == 8'h00}, 8'h00);
         if (uo_out == 8'h01 && first_ret == 0) first_ret = i;
      end
      check("lfsr_period", 8'(first_ret), 8'd255);
      ui_in = 8'h03; #1; check("cnt_ff", uo_out, 8'hFF);
      ui_in = 8'h07; step(); check("cnt_wrap", uo_out, 8'h00);

      // Rule-90 row from reset, then a long run against the reference.
      rst_n = 1'b1; step(); rst_n = 1'b0;
      ui_in = 8'h05;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("ca_step%0d", i + 1), uo_out, ca_exp[i]);
      end
      ca_m = 8'h80;
      for (int i = 4; i < 300; i++) begin
         ca_m = ca_ref(ca_m);
         step();
         check("ca_model", uo_out, ca_m);
         check("ca_nonzero", {7'b0, uo_out == 8'h00}, 8'h00);
      end

      // Load with a zero seed.
      ui_in = 8'h08; uio_in = 8'h00; step();
      ui_in = 8'h00; #1; check("load0_lfsr", uo_out, 8'h01);
      ui_in = 8'h01; #1; check("load0_ca", uo_out, 8'h08);
      ui_in = 8'h03; #1; check("load0_cnt", uo_out, 8'h00);

      // Load 0xA5 with run also high: load wins, counter cleared.
      ui_in = 8'h0C; uio_in = 8'hA5; step();
      ui_in = 8'h00; #1; check("loadA5_lfsr", uo_out, 8'hA5);
      ui_in = 8'h01; #1; check("loadA5_ca", uo_out, 8'hA5);
      ui_in = 8'h03; #1; check("loadA5_cnt", uo_out, 8'h00);

      // One run step from the loaded seed.
      ui_in = 8'h04; step();
      ui_in = 8'h00; #1; check("a5_step_lfsr", uo_out, 8'h4A);
      ui_in = 8'h01; #1; check("a5_step_ca", uo_out, 8'h18);
      ui_in = 8'h03; #1; check("a5_step_cnt", uo_out, 8'h01);
      ui_in = 8'h02; #1; check("a5_step_xor", uo_out, 8'h52);

      // Reset together with load and run in mid-sequence.
      ui_in = 8'h0C; uio_in = 8'h5A; rst_n = 1'b1; step();
      rst_n = 1'b0;
      ui_in = 8'h00; #1; check("midrst_lfsr", uo_out, 8'h01);
      ui_in = 8'h01; #1; check("midrst_ca", uo_out, 8'h08);
      ui_in = 8'h03; #1; check("midrst_cnt", uo_out, 8'h00);

      // Advance three steps, then hold for 10 cycles with ena low and
      // the unused ui_in bits set.
      ui_in = 8'h04; step(); step(); step();
      ena = 1'b0; ui_in = 8'hF0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("hold_lfsr", uo_out, 8'h08);
      end
      ui_in = 8'hF1; #1; check("hold_ca", uo_out, 8'h55);
      ui_in = 8'hF3; #1; check("hold_cnt", uo_out, 8'h03);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_tt_um_sierpinski_lfsr
